nk_serial_adder: RTL and testbench

- Parametrised multi-cycle base-2 adder: computes x + y + cin on N-bit operands.
- Processes K bits per clock with one K-bit ripple slice and a registered inter-slice carry, so N/K cycles per addition.
- Start/ready/done handshake; sits between operand registers and a consumer that can tolerate variable latency.
- Trades latency for area compared with a full-width combinational adder.

---
 rtl/nk_serial_adder.sv | 89 ++++++++
 tb/tb_nk_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nk_serial_adder.sv
// Multi-cycle adder: K bits per clock through one ripple slice, N/K cycles per add.
// Optional subtract mode enabled by defining NK_SERIAL_ADDER_SUB_EN.
module nk_serial_adder #(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
`ifdef NK_SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         done
);
    localparam int SLICES = N / K;
    localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  xr, yr;
    logic          c;
    logic [CW-1:0] cnt;
    logic [K:0]    slice;
    logic [N-1:0]  s_next;
    logic [N-1:0]  y_load;
    logic          c_load;

`ifdef NK_SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert y, force carry-in to one.
    assign y_load = sub ? ~y : y;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign y_load = y;
    assign c_load = cin;
`endif

    assign slice  = {1'b0, xr[K-1:0]} + {1'b0, yr[K-1:0]} + {{K{1'b0}}, c};
    // New slice enters at the top; after N/K slices slice 0 sits at the bottom.
    assign s_next = N'({slice[K-1:0], s} >> K);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= y_load;
                        c     <= c_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s   <= s_next;
                    xr  <= xr >> K;
                    yr  <= yr >> K;
                    c   <= slice[K];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout  <= slice[K];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_nk_serial_adder.sv
// Scoreboard bench for nk_serial_adder: N=16/K=4 main instance plus N=8 sweeps (K=1, K=8).
module tb_nk_serial_adder;
    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic        start, cin, sub;
    logic [15:0] x, y;
    logic        ready, cout, done;
    logic [15:0] s;

    logic        start8, cin8;
    logic [7:0]  x8, y8;
    logic        r1, co1, d1, r8, co8, d8;
    logic [7:0]  s1, s8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [16:0] q16[$];
    int          a16[$];
    logic [8:0]  q1[$], q8[$];
    int          a1[$], a8[$];

    always #5 clock = ~clock;

    nk_serial_adder #(.N(16), .K(4)) dut (
        .clock(clock), .reset_(reset_), .start(start), .x(x), .y(y), .cin(cin),
`ifdef NK_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .ready(ready), .s(s), .cout(cout), .done(done)
    );

    nk_serial_adder #(.N(8), .K(1)) dut_k1 (
        .clock(clock), .reset_(reset_), .start(start8), .x(x8), .y(y8), .cin(cin8),
`ifdef NK_SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .ready(r1), .s(s1), .cout(co1), .done(d1)
    );

    nk_serial_adder #(.N(8), .K(8)) dut_k8 (
        .clock(clock), .reset_(reset_), .start(start8), .x(x8), .y(y8), .cin(cin8),
`ifdef NK_SERIAL_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .ready(r8), .s(s8), .cout(co8), .done(d8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic sb);
        if (sb) return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, ci};
    endfunction

    // Push expectations on the accepting edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset_ && start && ready) begin
`ifdef NK_SERIAL_ADDER_SUB_EN
            q16.push_back(model16(x, y, cin, sub));
`else
            q16.push_back(model16(x, y, cin, 1'b0));
`endif
            a16.push_back(cyc);
        end
        if (reset_ && start8 && r1) begin
            q1.push_back({1'b0, x8} + {1'b0, y8} + {8'd0, cin8});
            a1.push_back(cyc);
        end
        if (reset_ && start8 && r8) begin
            q8.push_back({1'b0, x8} + {1'b0, y8} + {8'd0, cin8});
            a8.push_back(cyc);
        end
    end

    logic [16:0] e16;
    logic [8:0]  e1, e8;
    int          t16, t1, t8;

    always @(negedge clock) begin
        if (reset_) begin
            if (done) begin
                if (q16.size() == 0) chk("spur16", 1, 0);
                else begin
                    e16 = q16.pop_front();
                    t16 = a16.pop_front();
                    chk("s16", 32'(s), 32'(e16[15:0]));
                    chk("cout16", 32'(cout), 32'(e16[16]));
                    chk("lat16", 32'(cyc - t16 - 1), 32'd4);
                end
            end
            if (d1) begin
                if (q1.size() == 0) chk("spur_k1", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    t1 = a1.pop_front();
                    chk("s_k1", 32'({co1, s1}), 32'(e1));
                    chk("lat_k1", 32'(cyc - t1 - 1), 32'd8);
                end
            end
            if (d8) begin
                if (q8.size() == 0) chk("spur_k8", 1, 0);
                else begin
                    e8 = q8.pop_front();
                    t8 = a8.pop_front();
                    chk("s_k8", 32'({co8, s8}), 32'(e8));
                    chk("lat_k8", 32'(cyc - t8 - 1), 32'd1);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q16.size() != 0 || q1.size() != 0 || q8.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("timeout", 1, 0);
        @(negedge clock);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb);
        logic [16:0] e;
        e = model16(a, b, ci, sb);
        @(negedge clock);
        wait_ready();
        x = a; y = b; cin = ci; sub = sb; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("ready_drop", 32'(ready), 0);
        wait_idle();
        chk("hold16", 32'({cout, s}), 32'(e));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clock);
        x8 = a; y8 = b; cin8 = ci; start8 = 1'b1;
        @(negedge clock);
        start8 = 1'b0;
        wait_idle();
    endtask

    initial begin
        start = 0; x = 0; y = 0; cin = 0; sub = 0;
        start8 = 0; x8 = 0; y8 = 0; cin8 = 0;
        #3;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_s", 32'(s), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clock);
        reset_ = 1'b1;

        run16(16'h1234, 16'h4321, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // start held through RUN with different operands must not disturb the first add
        @(negedge clock);
        wait_ready();
        x = 16'h1234; y = 16'h4321; cin = 0; start = 1'b1;
        @(negedge clock);
        x = 16'h0001; y = 16'h0001;
        begin
            int n = 0;
            while (!ready && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // async reset in the second RUN cycle
        @(negedge clock);
        x = 16'h1234; y = 16'h4321; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #2;
        reset_ = 1'b0;
        #1;
        chk("abort_s", 32'(s), 0);
        chk("abort_cout", 32'(cout), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ready", 32'(ready), 1);
        q16.delete(); a16.delete();
        @(negedge clock);
        reset_ = 1'b1;
        repeat (8) @(negedge clock);
        run16(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

        run8(8'hA5, 8'h5B, 1'b0);
        run8(8'hFF, 8'h00, 1'b1);
        run8(8'h3C, 8'h42, 1'b1);

`ifdef NK_SERIAL_ADDER_SUB_EN
        run16(16'h0005, 16'h0007, 1'b0, 1'b1);
        run16(16'h0007, 16'h0005, 1'b0, 1'b1);
        run16(16'h0005, 16'h0007, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
